d_e_reg: RTL and testbench

- D/E pipeline register of the 5-stage MIPS pipeline.
- Directly downstream of the D-stage immediate extender: it latches `D_EXT_imm32`, the register-file read data, PC, instruction, destination register and Tnew at the end of D, and presents them to the E stage.
- Inserts bubbles on D-stage stalls and freezes while E is busy (mult/div).
- Keeps a bubble counter for performance/debug readout.

---
 rtl/d_e_reg.sv | 117 +++++++++++
 tb/tb_d_e_reg.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/d_e_reg.sv
// D/E pipeline register: latches decode-stage results for the execute stage.
// It loads normal instructions, inserts bubbles on flush and holds while E
// is busy. It also counts the bubbles it inserts.
// Optional build macro D_E_KEEP_PC_EN: when defined, a bubble keeps D_pc in
// E_pc so exception reporting and the trace display still see a PC.
module d_e_reg #(
  parameter int unsigned DW    = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             D_E_en,
  input  logic             D_E_flush,
  input  logic [DW-1:0]    D_pc,
  input  logic [DW-1:0]    D_instr,
  input  logic [DW-1:0]    D_rs_data,
  input  logic [DW-1:0]    D_rt_data,
  input  logic [DW-1:0]    D_EXT_imm32,
  input  logic [4:0]       D_A3,
  input  logic [1:0]       D_Tnew,
  output logic [DW-1:0]    E_pc,
  output logic [DW-1:0]    E_instr,
  output logic [DW-1:0]    E_rs_data,
  output logic [DW-1:0]    E_rt_data,
  output logic [DW-1:0]    E_EXT_imm32,
  output logic [4:0]       E_A3,
  output logic [1:0]       E_Tnew,
  output logic             E_valid,
  output logic [CNT_W-1:0] bubble_cnt
);

  logic [DW-1:0]    pc_q,    pc_d;
  logic [DW-1:0]    instr_q, instr_d;
  logic [DW-1:0]    rs_q,    rs_d;
  logic [DW-1:0]    rt_q,    rt_d;
  logic [DW-1:0]    imm_q,   imm_d;
  logic [4:0]       a3_q,    a3_d;
  logic [1:0]       tnew_q,  tnew_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;

  // Next-state selection: hold, bubble load or normal load.
  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    rs_d    = rs_q;
    rt_d    = rt_q;
    imm_d   = imm_q;
    a3_d    = a3_q;
    tnew_d  = tnew_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    if (D_E_en) begin
      if (D_E_flush) begin
`ifdef D_E_KEEP_PC_EN
        pc_d    = D_pc;
`else
        pc_d    = '0;
`endif
        instr_d = '0;
        rs_d    = '0;
        rt_d    = '0;
        imm_d   = '0;
        a3_d    = 5'd0;
        tnew_d  = 2'd0;
        valid_d = 1'b0;
        cnt_d   = cnt_q + CNT_W'(1);
      end else begin
        pc_d    = D_pc;
        instr_d = D_instr;
        rs_d    = D_rs_data;
        rt_d    = D_rt_data;
        imm_d   = D_EXT_imm32;
        a3_d    = D_A3;
        // One stage later, the result is one cycle closer; never below zero.
        tnew_d  = (D_Tnew == 2'd0) ? 2'd0 : D_Tnew - 2'd1;
        valid_d = 1'b1;
      end
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q    <= '0;
      instr_q <= '0;
      rs_q    <= '0;
      rt_q    <= '0;
      imm_q   <= '0;
      a3_q    <= 5'd0;
      tnew_q  <= 2'd0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      rs_q    <= rs_d;
      rt_q    <= rt_d;
      imm_q   <= imm_d;
      a3_q    <= a3_d;
      tnew_q  <= tnew_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  assign E_pc        = pc_q;
  assign E_instr     = instr_q;
  assign E_rs_data   = rs_q;
  assign E_rt_data   = rt_q;
  assign E_EXT_imm32 = imm_q;
  assign E_A3        = a3_q;
  assign E_Tnew      = tnew_q;
  assign E_valid     = valid_q;
  assign bubble_cnt  = cnt_q;

endmodule

// File: tb/tb_d_e_reg.sv
// Self-checking bench for d_e_reg: a behavioural model checked on every
// falling edge, plus directed literal expectations.
module tb_d_e_reg;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        D_E_en = 1'b0;
  logic        D_E_flush = 1'b0;
  logic [31:0] D_pc = '0, D_instr = '0, D_rs_data = '0, D_rt_data = '0, D_EXT_imm32 = '0;
  logic [4:0]  D_A3 = '0;
  logic [1:0]  D_Tnew = '0;

  logic [31:0] E_pc, E_instr, E_rs_data, E_rt_data, E_EXT_imm32;
  logic [4:0]  E_A3;
  logic [1:0]  E_Tnew;
  logic        E_valid;
  logic [15:0] bubble_cnt;

  logic [31:0] w_pc, w_instr, w_rs, w_rt, w_imm;
  logic [4:0]  w_a3;
  logic [1:0]  w_tnew;
  logic        w_valid;
  logic [3:0]  w_cnt;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  d_e_reg #(.DW(32), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .D_E_en(D_E_en), .D_E_flush(D_E_flush),
    .D_pc(D_pc), .D_instr(D_instr), .D_rs_data(D_rs_data), .D_rt_data(D_rt_data),
    .D_EXT_imm32(D_EXT_imm32), .D_A3(D_A3), .D_Tnew(D_Tnew),
    .E_pc(E_pc), .E_instr(E_instr), .E_rs_data(E_rs_data), .E_rt_data(E_rt_data),
    .E_EXT_imm32(E_EXT_imm32), .E_A3(E_A3), .E_Tnew(E_Tnew), .E_valid(E_valid),
    .bubble_cnt(bubble_cnt)
  );

  // Narrow-counter instance used for the wrap-around checks.
  d_e_reg #(.DW(32), .CNT_W(4)) dut_w (
    .clk(clk), .reset(reset), .D_E_en(D_E_en), .D_E_flush(D_E_flush),
    .D_pc(D_pc), .D_instr(D_instr), .D_rs_data(D_rs_data), .D_rt_data(D_rt_data),
    .D_EXT_imm32(D_EXT_imm32), .D_A3(D_A3), .D_Tnew(D_Tnew),
    .E_pc(w_pc), .E_instr(w_instr), .E_rs_data(w_rs), .E_rt_data(w_rt),
    .E_EXT_imm32(w_imm), .E_A3(w_a3), .E_Tnew(w_tnew), .E_valid(w_valid),
    .bubble_cnt(w_cnt)
  );

  // Behavioural model: what E must show after each edge.
  logic [31:0] m_pc = '0, m_instr = '0, m_rs = '0, m_rt = '0, m_imm = '0;
  logic [4:0]  m_a3 = '0;
  int          m_tnew = 0;
  logic        m_valid = 1'b0;
  int unsigned m_bubbles = 0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_pc = 0; m_instr = 0; m_rs = 0; m_rt = 0; m_imm = 0;
      m_a3 = 0; m_tnew = 0; m_valid = 0; m_bubbles = 0;
    end else if (D_E_en && D_E_flush) begin
`ifdef D_E_KEEP_PC_EN
      m_pc = D_pc;
`else
      m_pc = 0;
`endif
      m_instr = 0; m_rs = 0; m_rt = 0; m_imm = 0;
      m_a3 = 0; m_tnew = 0; m_valid = 0;
      m_bubbles = m_bubbles + 1;
    end else if (D_E_en) begin
      m_pc = D_pc; m_instr = D_instr; m_rs = D_rs_data; m_rt = D_rt_data;
      m_imm = D_EXT_imm32; m_a3 = D_A3; m_valid = 1;
      m_tnew = (int'(D_Tnew) > 0) ? int'(D_Tnew) - 1 : 0;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare both instances against the model on every falling edge.
  always @(negedge clk) begin
    chk("pc",      64'(E_pc),        64'(m_pc));
    chk("instr",   64'(E_instr),     64'(m_instr));
    chk("rs",      64'(E_rs_data),   64'(m_rs));
    chk("rt",      64'(E_rt_data),   64'(m_rt));
    chk("imm",     64'(E_EXT_imm32), 64'(m_imm));
    chk("a3",      64'(E_A3),        64'(m_a3));
    chk("tnew",    64'(E_Tnew),      64'(m_tnew));
    chk("valid",   64'(E_valid),     64'(m_valid));
    chk("cnt16",   64'(bubble_cnt),  64'(m_bubbles % 65536));
    chk("cnt4",    64'(w_cnt),       64'(m_bubbles % 16));
    chk("w_a3",    64'(w_a3),        64'(m_a3));
    chk("w_valid", 64'(w_valid),     64'(m_valid));
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic en, input logic fl, input logic [31:0] pc,
                       input logic [31:0] instr, input logic [31:0] imm,
                       input logic [4:0] a3, input logic [1:0] tnew);
    D_E_en = en; D_E_flush = fl; D_pc = pc; D_instr = instr;
    D_rs_data = pc ^ 32'h5555_0000; D_rt_data = instr ^ 32'h0000_aaaa;
    D_EXT_imm32 = imm; D_A3 = a3; D_Tnew = tnew;
  endtask

  logic [31:0] exp_bub_pc;

  initial begin
`ifdef D_E_KEEP_PC_EN
    exp_bub_pc = 32'h0000_3008;
`else
    exp_bub_pc = 32'h0;
`endif
    #1 reset = 1'b1;
    tick(); tick();
    chk("rst_pc", 64'(E_pc), 64'h0);
    chk("rst_valid", 64'(E_valid), 64'h0);
    chk("rst_cnt", 64'(bubble_cnt), 64'h0);
    reset = 1'b0;

    // Load, then reset between edges clears outputs immediately.
    drive(1, 0, 32'h0000_3000, 32'h3c01_1234, 32'h0, 5'd1, 2'd1);
    tick();
    chk("load_pc", 64'(E_pc), 64'h3000);
    chk("load_instr", 64'(E_instr), 64'h3c01_1234);
    #1 reset = 1'b1;
    #1;
    chk("arst_pc", 64'(E_pc), 64'h0);
    chk("arst_instr", 64'(E_instr), 64'h0);
    chk("arst_valid", 64'(E_valid), 64'h0);
    chk("arst_cnt", 64'(bubble_cnt), 64'h0);
    tick();
    reset = 1'b0;

    // Normal load with Tnew decrement.
    drive(1, 0, 32'h0000_3004, 32'h3421_5678, 32'h1234_0000, 5'd1, 2'd2);
    tick();
    chk("nl_pc", 64'(E_pc), 64'h3004);
    chk("nl_imm", 64'(E_EXT_imm32), 64'h1234_0000);
    chk("nl_a3", 64'(E_A3), 64'd1);
    chk("nl_tnew", 64'(E_Tnew), 64'd1);
    chk("nl_valid", 64'(E_valid), 64'd1);

    // Tnew saturation and top value.
    drive(1, 0, 32'h0000_3008, 32'h0000_0000, 32'h0, 5'd2, 2'd0);
    tick();
    chk("tnew0", 64'(E_Tnew), 64'd0);
    drive(1, 0, 32'h0000_300c, 32'h8c22_0004, 32'h4, 5'd3, 2'd3);
    tick();
    chk("tnew3", 64'(E_Tnew), 64'd2);

    // Three consecutive bubbles.
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 32'h0000_3008, 32'h2002_0007, 32'h7, 5'd5, 2'd2);
      tick();
      chk("bub_instr", 64'(E_instr), 64'h0);
      chk("bub_a3", 64'(E_A3), 64'h0);
      chk("bub_tnew", 64'(E_Tnew), 64'h0);
      chk("bub_valid", 64'(E_valid), 64'h0);
      chk("bub_cnt", 64'(bubble_cnt), 64'(i + 1));
      chk("bub_pc", 64'(E_pc), 64'(exp_bub_pc));
    end

    // Hold overrides flush while D inputs change.
    drive(1, 0, 32'h0000_4000, 32'hdead_beef, 32'hffff_fff0, 5'd9, 2'd1);
    tick();
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, 32'h0000_5000 + 32'(i * 4), 32'h1111_0000 + 32'(i), 32'h0, 5'd7, 2'd3);
      tick();
      chk("hold_pc", 64'(E_pc), 64'h4000);
      chk("hold_instr", 64'(E_instr), 64'hdead_beef);
      chk("hold_valid", 64'(E_valid), 64'd1);
      chk("hold_tnew", 64'(E_Tnew), 64'd0);
      chk("hold_cnt", 64'(bubble_cnt), 64'd3);
    end

    // Counter wrap on the 4-bit instance.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    drive(1, 1, 32'h0000_6000, 32'h0, 32'h0, 5'd4, 2'd1);
    for (int i = 0; i < 16; i++) tick();
    chk("wrap16_cnt4", 64'(w_cnt), 64'd0);
    chk("wrap16_cnt16", 64'(bubble_cnt), 64'd16);
    tick();
    chk("wrap17_cnt4", 64'(w_cnt), 64'd1);
    chk("wrap17_cnt16", 64'(bubble_cnt), 64'd17);

    drive(0, 0, 32'h0, 32'h0, 32'h0, 5'd0, 2'd0);
    tick(); tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
